// File: rtl/weight_bram_rmw.sv
// Layer weight store: registered read port for the MAC unit, and a read-modify-write update port (overwrite or saturating accumulate) with a hardware clear sweep.
// Read latency 1 cycle; an update is accepted at E0 and commits at E1, and upd_done pulses the cycle after E1.
// upd_ready drops while clear_start is high or a sweep runs; reads are always served.
module weight_bram_rmw #(
    parameter int                    NUM_NEURONS = 256,
    parameter int                    INPUT_SIZE  = 784,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = NUM_NEURONS * INPUT_SIZE,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
    parameter int                    SAT_CNT_W   = 16,
    localparam int                   AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic                  upd_mode,
    input  logic [AW-1:0]         upd_addr,
    input  logic [DATA_WIDTH-1:0] upd_data,
    output logic                  upd_done,
    input  logic                  clear_start,
    output logic                  busy,
    output logic [SAT_CNT_W-1:0]  sat_count
);

    localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_clr_go;
    logic                    w_clr_last;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_valid;

    logic                    r_s1_vld;
    logic [AW-1:0]           r_s1_addr;
    logic [DATA_WIDTH-1:0]   r_s1_data;
    logic                    r_s1_mode;
    logic [DATA_WIDTH-1:0]   r_s1_old;
    logic                    r_upd_done;

    logic [AW-1:0]           r_clr_addr;
    logic [SAT_CNT_W-1:0]    r_sat_cnt;

    logic                    w_upd_rdy;
    logic                    w_upd_fire;
    logic                    w_fwd;
    logic [DATA_WIDTH-1:0]   w_old;
    logic [DATA_WIDTH:0]     w_sum;
    logic                    w_ovf;
    logic [DATA_WIDTH-1:0]   w_sat_val;
    logic [DATA_WIDTH-1:0]   w_result;
    logic                    w_sat_evt;
    logic                    w_sweep;
    logic                    w_wr_en;
    logic [AW-1:0]           w_wr_addr;
    logic [DATA_WIDTH-1:0]   w_wr_data;

    // Clear wins over a simultaneous update request; nothing is accepted during a sweep.
    assign w_upd_rdy  = (r_state == ST_IDLE) && !clear_start;
    assign w_upd_fire = upd_valid && w_upd_rdy;
    assign w_sweep    = (r_state == ST_CLEAR);
    assign w_clr_last = (r_clr_addr == AW'(DEPTH - 1));

    // Next-state logic: a request in IDLE starts the sweep; the in-flight S1 op commits on that same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_go    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_start) begin
                    w_state_nxt = ST_CLEAR;
                    w_clr_go    = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (w_clr_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sweep address counter: restarts at 0 on each clear, steps once per sweep cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_addr <= '0;
        end else if (w_clr_go) begin
            r_clr_addr <= '0;
        end else if (w_sweep) begin
            r_clr_addr <= r_clr_addr + AW'(1);
        end
    end

    // Saturating accumulate: widen by one bit and clamp when the top two sum bits disagree.
    always_comb begin
        w_sum     = {r_s1_old[DATA_WIDTH-1], r_s1_old} + {r_s1_data[DATA_WIDTH-1], r_s1_data};
        w_ovf     = (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1]);
        w_sat_val = w_sum[DATA_WIDTH-1:0];
        if (w_ovf) begin
            w_sat_val = w_sum[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
        end
        w_result  = r_s1_mode ? w_sat_val : r_s1_data;
        w_sat_evt = r_s1_vld && r_s1_mode && w_ovf;
    end

    // Single write port shared by update commit and sweep; the two never overlap.
    always_comb begin
        w_wr_en   = r_s1_vld || w_sweep;
        w_wr_addr = w_sweep ? r_clr_addr : r_s1_addr;
        w_wr_data = w_sweep ? INIT_VALUE : w_result;
    end

    // Old value for a newly accepted op: take the committing S1 result on an address match.
    always_comb begin
        w_fwd = r_s1_vld && (r_s1_addr == upd_addr);
        w_old = w_fwd ? w_result : r_mem[upd_addr];
    end

    // Memory array, not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Read port, read-first against a same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= r_mem[rd_addr];
            end
        end
    end

    // S1 valid and the commit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_upd_done <= 1'b0;
        end else begin
            r_s1_vld   <= w_upd_fire;
            r_upd_done <= r_s1_vld;
        end
    end

    // S1 payload captured on accept.
    always_ff @(posedge clk) begin
        if (w_upd_fire) begin
            r_s1_addr <= upd_addr;
            r_s1_data <= upd_data;
            r_s1_mode <= upd_mode;
            r_s1_old  <= w_old;
        end
    end

    // Saturation event counter: cleared at sweep start, sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (w_clr_go) begin
            r_sat_cnt <= '0;
        end else if (w_sat_evt && !(&r_sat_cnt)) begin
            r_sat_cnt <= r_sat_cnt + SAT_CNT_W'(1);
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign upd_ready = w_upd_rdy;
    assign upd_done  = r_upd_done;
    assign busy      = w_sweep;
    assign sat_count = r_sat_cnt;

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    generate
        if (DEPTH < (2 ** AW)) begin : g_addr_chk
            a_rd_addr : assert property (@(posedge clk) disable iff (!rst_n)
                rd_en |-> (32'(rd_addr) < DEPTH));
            a_upd_addr : assert property (@(posedge clk) disable iff (!rst_n)
                upd_valid |-> (32'(upd_addr) < DEPTH));
        end
    endgenerate

endmodule

// File: tb/tb_weight_bram_rmw.sv
module tb_weight_bram_rmw;

    localparam logic [31:0] INIT = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        upd_valid;
    logic        upd_ready;
    logic        upd_mode;
    logic [3:0]  upd_addr;
    logic [31:0] upd_data;
    logic        upd_done;
    logic        clear_start;
    logic        busy;
    logic [15:0] sat_count;

    int n_checks = 0;
    int n_pass   = 0;

    weight_bram_rmw #(
        .NUM_NEURONS(4),
        .INPUT_SIZE (4),
        .DATA_WIDTH (32),
        .INIT_VALUE (INIT),
        .SAT_CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_mode   (upd_mode),
        .upd_addr   (upd_addr),
        .upd_data   (upd_data),
        .upd_done   (upd_done),
        .clear_start(clear_start),
        .busy       (busy),
        .sat_count  (sat_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Entered at a negedge: issue one update, return two negedges later with it committed.
    task automatic upd(input logic m, input logic [3:0] a, input logic [31:0] d);
        upd_valid = 1'b1; upd_mode = m; upd_addr = a; upd_data = d;
        @(negedge clk);
        upd_valid = 1'b0;
        @(negedge clk);
    endtask

    // Entered at a negedge: single read, returns the data one cycle later.
    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        d = rd_data;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data got %h want 0", rd_data); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (upd_done !== 1'b0) $display("FAIL reset_upd_done got %b want 0", upd_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (sat_count !== 16'h0) $display("FAIL reset_sat_count got %h want 0", sat_count); else n_pass++;
        n_checks++; if (upd_ready !== 1'b1) $display("FAIL reset_upd_ready got %b want 1", upd_ready); else n_pass++;
    endtask

    task automatic test_overwrite();
        upd_valid = 1'b1; upd_mode = 1'b0; upd_addr = 4'd5; upd_data = 32'h0001_8000;
        @(negedge clk);
        n_checks++; if (upd_done !== 1'b0) $display("FAIL ow_done_early got %b want 0", upd_done); else n_pass++;
        upd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (upd_done !== 1'b1) $display("FAIL ow_done got %b want 1", upd_done); else n_pass++;
        rd_en = 1'b1; rd_addr = 4'd5;
        @(negedge clk);
        rd_en = 1'b0;
        n_checks++; if (upd_done !== 1'b0) $display("FAIL ow_done_width got %b want 0", upd_done); else n_pass++;
        n_checks++; if (rd_data !== 32'h0001_8000) $display("FAIL ow_rd_data got %h want 00018000", rd_data); else n_pass++;
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL ow_rd_valid got %b want 1", rd_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL ow_rd_valid_drop got %b want 0", rd_valid); else n_pass++;
    endtask

    task automatic test_forwarding();
        logic [31:0] d;
        upd(1'b0, 4'd7, 32'h0001_0000);
        upd_valid = 1'b1; upd_mode = 1'b1; upd_addr = 4'd7; upd_data = 32'h0000_4000;
        @(negedge clk);
        n_checks++; if (upd_done !== 1'b0) $display("FAIL fwd_done0 got %b want 0", upd_done); else n_pass++;
        @(negedge clk);
        n_checks++; if (upd_done !== 1'b1) $display("FAIL fwd_done1 got %b want 1", upd_done); else n_pass++;
        @(negedge clk);
        upd_valid = 1'b0;
        n_checks++; if (upd_done !== 1'b1) $display("FAIL fwd_done2 got %b want 1", upd_done); else n_pass++;
        @(negedge clk);
        n_checks++; if (upd_done !== 1'b1) $display("FAIL fwd_done3 got %b want 1", upd_done); else n_pass++;
        @(negedge clk);
        n_checks++; if (upd_done !== 1'b0) $display("FAIL fwd_done_end got %b want 0", upd_done); else n_pass++;
        rd(4'd7, d);
        n_checks++; if (d !== 32'h0001_C000) $display("FAIL fwd_value got %h want 0001c000", d); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        upd(1'b0, 4'd3, 32'h7FFF_0000);
        upd(1'b1, 4'd3, 32'h0002_0000);
        rd(4'd3, d);
        n_checks++; if (d !== 32'h7FFF_FFFF) $display("FAIL sat_pos got %h want 7fffffff", d); else n_pass++;
        n_checks++; if (sat_count !== 16'd1) $display("FAIL sat_cnt1 got %0d want 1", sat_count); else n_pass++;
        upd(1'b0, 4'd4, 32'h8001_0000);
        upd(1'b1, 4'd4, 32'hFFFD_0000);
        rd(4'd4, d);
        n_checks++; if (d !== 32'h8000_0000) $display("FAIL sat_neg got %h want 80000000", d); else n_pass++;
        n_checks++; if (sat_count !== 16'd2) $display("FAIL sat_cnt2 got %0d want 2", sat_count); else n_pass++;
        upd(1'b0, 4'd12, 32'h7FFF_0000);
        upd(1'b1, 4'd12, 32'h0000_FFFF);
        rd(4'd12, d);
        n_checks++; if (d !== 32'h7FFF_FFFF) $display("FAIL sat_edge got %h want 7fffffff", d); else n_pass++;
        n_checks++; if (sat_count !== 16'd2) $display("FAIL sat_edge_cnt got %0d want 2", sat_count); else n_pass++;
    endtask

    task automatic test_collision();
        logic [31:0] d;
        upd(1'b0, 4'd9, 32'h0000_1111);
        upd_valid = 1'b1; upd_mode = 1'b0; upd_addr = 4'd9; upd_data = 32'h0000_AAAA;
        @(negedge clk);
        upd_valid = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd9;
        @(negedge clk);
        rd_en = 1'b0;
        n_checks++; if (rd_data !== 32'h0000_1111) $display("FAIL coll_old got %h want 00001111", rd_data); else n_pass++;
        n_checks++; if (upd_done !== 1'b1) $display("FAIL coll_done got %b want 1", upd_done); else n_pass++;
        rd(4'd9, d);
        n_checks++; if (d !== 32'h0000_AAAA) $display("FAIL coll_new got %h want 0000aaaa", d); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        upd_valid = 1'b1; upd_mode = 1'b0; upd_addr = 4'd2;  upd_data = 32'd5;
        @(negedge clk);
        upd_mode = 1'b1; upd_addr = 4'd2;  upd_data = 32'd3;
        @(negedge clk);
        upd_mode = 1'b0; upd_addr = 4'd11; upd_data = 32'h77;
        @(negedge clk);
        upd_mode = 1'b1; upd_addr = 4'd2;  upd_data = 32'hFFFF_FFF6;
        @(negedge clk);
        upd_valid = 1'b0;
        @(negedge clk);
        rd(4'd2, d);
        n_checks++; if (d !== 32'hFFFF_FFFE) $display("FAIL b2b_addr2 got %h want fffffffe", d); else n_pass++;
        rd(4'd11, d);
        n_checks++; if (d !== 32'h0000_0077) $display("FAIL b2b_addr11 got %h want 00000077", d); else n_pass++;
        n_checks++; if (sat_count !== 16'd2) $display("FAIL b2b_sat got %0d want 2", sat_count); else n_pass++;
    endtask

    task automatic test_clear();
        int  cnt;
        bit  ready_bad;
        bit  extra_done;
        upd_valid = 1'b1; upd_mode = 1'b0; upd_addr = 4'd1; upd_data = 32'h55;
        @(negedge clk);
        upd_addr = 4'd14; upd_data = 32'hBAD;
        clear_start = 1'b1;
        #1;
        n_checks++; if (upd_ready !== 1'b0) $display("FAIL clr_ready_start got %b want 0", upd_ready); else n_pass++;
        @(negedge clk);
        clear_start = 1'b0;
        n_checks++; if (upd_done !== 1'b1) $display("FAIL clr_inflight_done got %b want 1", upd_done); else n_pass++;
        n_checks++; if (sat_count !== 16'd0) $display("FAIL clr_sat_reset got %0d want 0", sat_count); else n_pass++;
        cnt = 0; ready_bad = 1'b0; extra_done = 1'b0;
        if (busy) begin
            cnt = 1;
            if (upd_ready) ready_bad = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            clear_start = 1'b0;
            if (!busy) begin
                upd_valid = 1'b0;
                break;
            end
            cnt++;
            if (upd_ready) ready_bad = 1'b1;
            if (upd_done) extra_done = 1'b1;
            if (i == 5) clear_start = 1'b1;
        end
        upd_valid = 1'b0;
        clear_start = 1'b0;
        n_checks++; if (cnt != 16) $display("FAIL clr_busy_cycles got %0d want 16", cnt); else n_pass++;
        n_checks++; if (ready_bad) $display("FAIL clr_ready_busy got 1 want 0"); else n_pass++;
        n_checks++; if (extra_done) $display("FAIL clr_stray_done got 1 want 0"); else n_pass++;
        rd_en = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            @(negedge clk);
            n_checks++;
            if (rd_data !== INIT || rd_valid !== 1'b1)
                $display("FAIL clr_word%0d got %h valid %b want %h valid 1", a, rd_data, rd_valid, INIT);
            else n_pass++;
        end
        rd_en = 1'b0;
        n_checks++; if (sat_count !== 16'd0) $display("FAIL clr_sat_end got %0d want 0", sat_count); else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] d;
        clear_start = 1'b1;
        rd_en = 1'b1; rd_addr = 4'd15;
        @(negedge clk);
        clear_start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL rmc_busy_before got %b want 1", busy); else n_pass++;
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== INIT)
            $display("FAIL rmc_read_during_clear got %h valid %b want %h valid 1", rd_data, rd_valid, INIT);
        else n_pass++;
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmc_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL rmc_rd_valid got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== 32'h0) $display("FAIL rmc_rd_data got %h want 0", rd_data); else n_pass++;
        n_checks++; if (upd_done !== 1'b0) $display("FAIL rmc_upd_done got %b want 0", upd_done); else n_pass++;
        n_checks++; if (sat_count !== 16'h0) $display("FAIL rmc_sat got %0d want 0", sat_count); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (upd_ready !== 1'b1) $display("FAIL rmc_ready got %b want 1", upd_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rmc_busy_after got %b want 0", busy); else n_pass++;
        upd(1'b0, 4'd6, 32'h0000_CAFE);
        rd(4'd6, d);
        n_checks++; if (d !== 32'h0000_CAFE) $display("FAIL rmc_post_update got %h want 0000cafe", d); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        upd_valid = 1'b0; upd_mode = 1'b0; upd_addr = '0; upd_data = '0;
        clear_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        test_overwrite();
        test_forwarding();
        test_saturation();
        test_collision();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/weight_bram_rmw.md
Name: weight_bram_rmw

Overview:
- Single-clock successor to the layer weight memory; holds one layer's Q16.16 weights.
- Adds an in-place read-modify-write update port for the plasticity engine: accumulate a signed delta with saturation, or overwrite.
- Adds a hardware clear sequencer that sweeps every address to a parameterised init value.
- Sits between the MAC unit (read port) and the plasticity engine (update port); one instance per layer.

Parameters:
- NUM_NEURONS, 256, neurons in the layer
- INPUT_SIZE, 784, weights per neuron; addr = neuron_idx*INPUT_SIZE + weight_idx
- DATA_WIDTH, 32, weight width (signed, Q16.16 at default)
- DEPTH, NUM_NEURONS*INPUT_SIZE, memory words
- INIT_VALUE, 0, word written by the clear sweep
- SAT_CNT_W, 16, width of the saturation event counter

Ports:
- clk, in, 1, single clock for all logic
- rst_n, in, 1, asynchronous active-low reset
- rd_en, in, 1, MAC read request
- rd_addr, in, AW=$clog2(DEPTH), MAC read address
- rd_data, out, DATA_WIDTH, read data
- rd_valid, out, 1, rd_data valid; 1 cycle after rd_en
- upd_valid, in, 1, update request valid
- upd_ready, out, 1, update accepted when upd_valid&&upd_ready
- upd_mode, in, 1, 0=overwrite, 1=accumulate
- upd_addr, in, AW, update address
- upd_data, in, DATA_WIDTH, new value (mode 0) or signed delta (mode 1)
- upd_done, out, 1, 1-cycle pulse when an update's write commits
- clear_start, in, 1, pulse: begin the clear sweep
- busy, out, 1, clear sweep in progress
- sat_count, out, SAT_CNT_W, saturation events since the last clear; sticks at all-ones

Behaviour:
- Reset: rd_data=0, rd_valid=0, upd_done=0, busy=0, sat_count=0, FSM=IDLE, pipeline stage invalid. Memory array is not reset.
- Read port: registered, latency 1. rd_valid<=rd_en. rd_data updates only when rd_en=1.
- Read/write collision: a read and a write to the same address on the same edge returns the old value (read-first). Reads are always served, including during CLEAR.
- Update pipeline, 2 stages, throughput 1 per cycle:
  - Edge E0 (accept): capture addr, data and mode into S1; capture old=mem[upd_addr].
  - Cycle after E0, combinational: result = upd_data (mode 0), or sat(old + delta) (mode 1).
  - Edge E1: mem[S1.addr] <= result; upd_done=1 for the cycle after E1.
- Hazard forwarding: if an update is accepted at E1 to the same address as the S1 op committing at E1, the new op's old takes the S1 result instead of the stale memory value. Back-to-back accumulates to one address must be exact.
- Saturation (mode 1 only): compute the sum at DATA_WIDTH+1 bits.
  - Above 2^(DW-1)-1: clamp to max. Below -2^(DW-1): clamp to min.
  - Each clamp increments sat_count; sat_count holds at all-ones.
- upd_ready = (FSM==IDLE) && !clear_start.
- FSM IDLE -> CLEAR on clear_start:
  - Wait for an in-flight S1 op to commit first; it still pulses upd_done.
  - Then busy=1; write INIT_VALUE to addr 0..DEPTH-1, one per cycle, through the update write path.
  - After writing DEPTH-1: busy=0, return to IDLE.
  - sat_count cleared when the sweep starts.
- clear_start while busy: ignored. clear_start together with upd_valid: the clear wins and the update is not accepted.
- Reset mid-sweep: FSM=IDLE, busy=0; memory contents partially cleared and undefined.
- Address wrap: addresses >= DEPTH are illegal (assertion in simulation); no wrap logic.

Test Plan:
- Overwrite then read: upd mode0 addr 5 data 0x0001_8000 -> upd_done 2 cycles after accept; rd addr 5 one cycle later -> 0x0001_8000, rd_valid for 1 cycle.
- Forwarding: mem[7]=0x0001_0000; accumulate +0x0000_4000 to addr 7 on three consecutive cycles -> final 0x0001_C000; three upd_done pulses on consecutive cycles.
- Saturation: mem[3]=0x7FFF_0000, accumulate +0x0002_0000 -> 0x7FFF_FFFF, sat_count=1. mem[4]=0x8001_0000, accumulate -0x0003_0000 -> 0x8000_0000, sat_count=2.
- Collision: write addr 9 = 0xAAAA committing on the same edge as rd addr 9 (old 0x1111) -> rd_data 0x1111; the next read returns 0xAAAA.
- Clear with DEPTH=16, INIT_VALUE=0x0000_0100: clear_start while an update is in flight -> update commits, then busy for exactly 16 cycles and upd_ready=0 throughout; all 16 reads return 0x0000_0100; sat_count=0.
- Reset mid-clear after 5 writes -> busy=0, upd_ready=1 next cycle; all outputs at their reset values.
